irrigation_scheduler: RTL

Sequences one irrigation cycle end to end. It latches the irrigation mode, loads and runs the MM:S countdown shown on the 7-segment displays, and drives the sprinkler pump and dripper valve only while the cycle is active. It also pauses on low water, locks out re-triggering during a cooldown, and owns the hysteretic water-supply refill valve. It sits between the prerequisite/selector logic and the output LEDs and displays, replacing the free-running down counters.

---
 rtl/irrigation_pkg.sv | 20 ++
 rtl/irrigation_scheduler_if.sv | 32 +++
 rtl/bcd_down_timer.sv | 34 +++
 rtl/irrigation_scheduler.sv | 83 ++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared state encoding, BCD digit type and digit limits for the irrigation scheduler
package irrigation_pkg;
    localparam int DIGIT_W = 4;
    typedef logic [DIGIT_W-1:0] digit_t;
    localparam digit_t MD_MAX = 4'd3;
    localparam digit_t MU_MAX = 4'd9;
    localparam digit_t SD_MAX = 4'd5;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_IRRIGATE = 3'd2;
    localparam logic [2:0] S_PAUSE    = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;
    localparam logic [2:0] S_FAULT    = 3'd5;
    function automatic logic is_busy(input logic [2:0] s);
        return s == S_LOAD || s == S_IRRIGATE || s == S_PAUSE;
    endfunction
    function automatic digit_t clamp_digit(input digit_t d, input digit_t lim);
        return d > lim ? lim : d;
    endfunction
endpackage

// File: rtl/irrigation_scheduler_if.sv
// irrigation_scheduler_if: request, sensor and output signals between the selector logic and the scheduler
interface irrigation_scheduler_if;
    import irrigation_pkg::*;
    logic       tick;
    logic       irrigation_request;
    logic       splinker_mode;
    logic       conflicting_values;
    logic       low_water_level;
    logic       mid_water_level;
    logic       high_water_level;
    logic       splinker_bomb;
    logic       dripper_valvule;
    logic       water_supply_valvule;
    digit_t     minutes_d;
    digit_t     minutes_u;
    digit_t     seconds_d;
    logic       busy;
    logic       done;
    logic [2:0] state;
    modport master (
        output tick, irrigation_request, splinker_mode, conflicting_values,
               low_water_level, mid_water_level, high_water_level,
        input  splinker_bomb, dripper_valvule, water_supply_valvule,
               minutes_d, minutes_u, seconds_d, busy, done, state
    );
    modport slave (
        input  tick, irrigation_request, splinker_mode, conflicting_values,
               low_water_level, mid_water_level, high_water_level,
        output splinker_bomb, dripper_valvule, water_supply_valvule,
               minutes_d, minutes_u, seconds_d, busy, done, state
    );
endinterface

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: MM:S BCD countdown (minutes tens/units, seconds tens) that saturates at 00:0
module bcd_down_timer
    import irrigation_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [11:0] load_value,
    input  logic        enable,
    input  logic        clear,
    output digit_t      minutes_d,
    output digit_t      minutes_u,
    output digit_t      seconds_d,
    output logic        zero
);
    assign zero = minutes_d == '0 && minutes_u == '0 && seconds_d == '0;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            minutes_d <= '0;
            minutes_u <= '0;
            seconds_d <= '0;
        end else if (load) begin
            minutes_d <= clamp_digit(load_value[11:8], MD_MAX);
            minutes_u <= clamp_digit(load_value[7:4], MU_MAX);
            seconds_d <= clamp_digit(load_value[3:0], SD_MAX);
        end else if (enable && !zero) begin
            // borrow ripples seconds -> minute units -> minute tens
            seconds_d <= seconds_d == '0 ? SD_MAX : seconds_d - 4'd1;
            minutes_u <= seconds_d != '0 ? minutes_u : (minutes_u == '0 ? MU_MAX : minutes_u - 4'd1);
            minutes_d <= (seconds_d == '0 && minutes_u == '0) ? minutes_d - 4'd1 : minutes_d;
        end
    end
endmodule

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: sequences one irrigation cycle, drives pump/dripper while active,
// pauses on low water, enforces cooldown and owns the hysteretic refill valve.
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter logic [11:0] SPLINKER_TIME  = 12'h050,
    parameter logic [11:0] DRIPPER_TIME   = 12'h150,
    parameter int          COOLDOWN_TICKS = 6
) (
    input logic clock,
    input logic reset,
    irrigation_scheduler_if.slave bus
);
    logic [2:0] state_q, next;
    logic       mode_q;
    logic [5:0] cd_q;
    logic       zero, load, clear, enable;

    always_comb begin
        next = S_IDLE;
        case (state_q)
            S_IDLE:
                next = bus.conflicting_values ? S_FAULT :
                       (bus.irrigation_request && bus.low_water_level) ? S_LOAD : S_IDLE;
            S_LOAD, S_IRRIGATE, S_PAUSE:
                next = bus.conflicting_values      ? S_FAULT :
                       !bus.irrigation_request     ? S_IDLE  :
                       !bus.low_water_level        ? S_PAUSE :
                       (state_q == S_IRRIGATE && bus.tick && zero) ? S_COOLDOWN : S_IRRIGATE;
            S_COOLDOWN:
                next = bus.conflicting_values ? S_FAULT :
                       (bus.tick && cd_q == 6'(COOLDOWN_TICKS - 1)) ? S_IDLE : S_COOLDOWN;
            S_FAULT:
                next = bus.conflicting_values ? S_FAULT : S_IDLE;
            default:
                next = S_IDLE;
        endcase
    end

    // the timer is only meaningful while a cycle is in flight; everywhere else it reads 00:0
    assign load   = state_q == S_IDLE && next == S_LOAD;
    assign clear  = !is_busy(next);
    assign enable = state_q == S_IRRIGATE && next == S_IRRIGATE && bus.tick;

    bcd_down_timer u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (bus.splinker_mode ? SPLINKER_TIME : DRIPPER_TIME),
        .enable     (enable),
        .clear      (clear),
        .minutes_d  (bus.minutes_d),
        .minutes_u  (bus.minutes_u),
        .seconds_d  (bus.seconds_d),
        .zero       (zero)
    );

    assign bus.state = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q                  <= S_IDLE;
            mode_q                   <= 1'b0;
            cd_q                     <= '0;
            bus.splinker_bomb        <= 1'b0;
            bus.dripper_valvule      <= 1'b0;
            bus.water_supply_valvule <= 1'b0;
            bus.busy                 <= 1'b0;
            bus.done                 <= 1'b0;
        end else begin
            state_q             <= next;
            mode_q              <= load ? bus.splinker_mode : mode_q;
            cd_q                <= state_q != S_COOLDOWN ? '0 : cd_q + {5'd0, bus.tick};
            bus.splinker_bomb   <= next == S_IRRIGATE && mode_q;
            bus.dripper_valvule <= next == S_IRRIGATE && !mode_q;
            bus.busy            <= is_busy(next);
            bus.done            <= state_q == S_IRRIGATE && next == S_COOLDOWN;
            // refill hysteresis: open below mid, close at high; a sensor fault forces it shut
            bus.water_supply_valvule <= (bus.conflicting_values || state_q == S_FAULT || bus.high_water_level) ? 1'b0 :
                                        !bus.mid_water_level ? 1'b1 : bus.water_supply_valvule;
        end
    end
endmodule
